load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
//
// PURPOSE
//  Sits directly upstream of the word-only data memory in the MEM stage. It accepts RV32I
//  load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) from the pipeline.
//  Loads are registered, then sign- or zero-extended by byte lane. SW is one write cycle.
//  SB/SH are two-cycle read-modify-write sequences, since memory has no byte enables.
//  Misaligned, out-of-range or illegal-funct3 requests are flagged and never write memory.
//
// PARAMETERS
//  MEM_WORDS  32  words behind this unit; legal byte addr < MEM_WORDS*4 (power of 2)
//
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  req_valid    in   1   request present this cycle; held stable while stall=1
//  req_store    in   1   1 = store, 0 = load
//  req_funct3   in   3   000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only)
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  mem_we       out  1   write enable to data memory
//  mem_addr     out  32  word-aligned address {addr[31:2],2'b00}
//  mem_wd       out  32  write data to data memory
//  mem_rd       in   32  combinational read data from data memory
//  stall        out  1   hold pipeline; request must not change
//  load_data    out  32  extended load result, registered
//  load_valid   out  1   1-cycle pulse, cycle after load accepted
//  access_err   out  1   1-cycle pulse, cycle after faulting request
//
// BEHAVIOUR
//  FSM states: IDLE, RMW_WRITE. Reset (async, reset=0) -> IDLE.
//  Reset values: load_data=0, load_valid=0, access_err=0; mem_we=0 while reset=0.
//  Fault (evaluated in IDLE): any one of
//   - H/HU with addr[0]=1
//   - W with addr[1:0]!=0
//   - addr >= MEM_WORDS*4
//   - funct3 in {011,110,111}
//   - funct3 in {100,101} with req_store=1
//  On fault: mem_we=0, stall=0, next cycle access_err=1, load_valid=0, load_data unchanged.
//  IDLE, load: mem_addr from req_addr. Next edge latches extended lane into load_data
//   and sets load_valid=1 (latency 1). stall=0.
//  Lane select: byte = mem_rd[8*addr[1:0] +: 8]; half = mem_rd[16*addr[1] +: 16].
//   B/H sign-extend; BU/HU zero-extend; W passes through.
//  IDLE, SW: mem_we=1, mem_wd=req_wdata, stall=0. Write lands at this edge.
//  IDLE, SB/SH: mem_we=0, stall=1. Edge latches the merged word
//   (mem_rd with the selected lane replaced by req_wdata low bits) and the word address.
//   Next state is RMW_WRITE.
//  RMW_WRITE: mem_we=1, mem_addr/mem_wd from latched regs, stall=0. Next state is IDLE.
//  req_valid=0 in IDLE: mem_we=0, stall=0, no pulses. In RMW_WRITE, req inputs are ignored.
//  Reset asserted in RMW_WRITE: mem_we drops immediately, no write occurs, state -> IDLE.
//  Back-to-back: the request after RMW_WRITE sees the updated word (memory writes sync,
//   reads comb).
//
// TESTING
//  1. Mem[1]=0x11223344; SB addr 0x05, wdata 0xAB -> C1 stall=1, mem_we=0;
//     C2 mem_we=1, mem_wd=0x1122AB44; C3 stall=0.
//  2. Mem word 0x80FF0000; LB addr 0x03 -> next cycle load_data=0xFFFFFF80, load_valid=1;
//     LBU -> 0x00000080; LHU addr 0x02 -> 0x000080FF.
//  3. LH addr 0x03 and SW addr 0x06 -> access_err pulse each; no mem_we; load_valid=0.
//  4. SW addr 0x7C, wdata 0xDEADBEEF (MEM_WORDS=32) -> single cycle mem_we=1,
//     mem_addr=0x7C, stall=0. SW addr 0x80 -> access_err=1, no write.
//  5. SH addr 0x0A, wdata 0x1234 over word 0; then LHU addr 0x0A -> load_data=0x00001234.
//  6. Start SB, drive reset=0 during RMW_WRITE -> mem_we=0 at once, word unchanged;
//     after release, state IDLE and all outputs 0.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-only data memory.
// Sub-word stores become a read-modify-write pair; faulting requests never write.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_err
);

  localparam int unsigned AddrBits = $clog2(MEM_WORDS * 4);

  typedef enum logic [0:0] {StIdle, StRmwWrite} state_e;

  state_e      state_q;
  logic [31:0] rmw_addr_q;
  logic [31:0] rmw_data_q;
  logic [31:0] load_data_q;
  logic        load_valid_q;
  logic        access_err_q;

  logic        fault;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic [4:0]  byte_sel;
  logic [4:0]  half_sel;

  assign byte_sel  = {req_addr[1:0], 3'b000};
  assign half_sel  = {req_addr[1], 4'b0000};
  assign byte_lane = mem_rd[byte_sel +: 8];
  assign half_lane = mem_rd[half_sel +: 16];

  always_comb begin
    fault = (req_addr[31:AddrBits] != '0);
    case (req_funct3)
      3'b000:  ;
      3'b001:  if (req_addr[0]) fault = 1'b1;
      3'b010:  if (req_addr[1:0] != 2'b00) fault = 1'b1;
      3'b100:  if (req_store) fault = 1'b1;
      3'b101:  if (req_store || req_addr[0]) fault = 1'b1;
      default: fault = 1'b1;
    endcase
  end

  always_comb begin
    case (req_funct3)
      3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_ext = {24'h0, byte_lane};
      3'b101:  load_ext = {16'h0, half_lane};
      default: load_ext = mem_rd;
    endcase
  end

  // Merge store data into the current word; only B/H reach the RMW path.
  always_comb begin
    merged = mem_rd;
    if (req_funct3[0]) begin
      merged[half_sel +: 16] = req_wdata[15:0];
    end else begin
      merged[byte_sel +: 8] = req_wdata[7:0];
    end
  end

  // Write enable is gated by reset so an in-flight RMW write is dropped at once.
  always_comb begin
    mem_we   = 1'b0;
    stall    = 1'b0;
    mem_addr = {req_addr[31:2], 2'b00};
    mem_wd   = req_wdata;
    if (state_q == StRmwWrite) begin
      mem_we   = reset;
      mem_addr = rmw_addr_q;
      mem_wd   = rmw_data_q;
    end else if (req_valid && !fault && req_store) begin
      if (req_funct3 == 3'b010) begin
        mem_we = reset;
      end else begin
        stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      rmw_addr_q   <= '0;
      rmw_data_q   <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      access_err_q <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      access_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (fault) begin
              access_err_q <= 1'b1;
            end else if (!req_store) begin
              load_data_q  <= load_ext;
              load_valid_q <= 1'b1;
            end else if (req_funct3 != 3'b010) begin
              rmw_addr_q <= {req_addr[31:2], 2'b00};
              rmw_data_q <= merged;
              state_q    <= StRmwWrite;
            end
          end
        end
        StRmwWrite: state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign access_err = access_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural word memory, reference memory
// image and a pulse scoreboard for load_valid / access_err results.
module tb_load_store_unit;

  localparam int unsigned MemWords = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        access_err;

  load_store_unit #(.MEM_WORDS(MemWords)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .access_err (access_err)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [MemWords];
  logic [31:0] ref_mem [MemWords];
  logic        tb_we;
  logic [4:0]  tb_wa;
  logic [31:0] tb_wd;

  always @(posedge clk) begin
    if (tb_we) mem[tb_wa] <= tb_wd;
    else if (mem_we) mem[mem_addr[6:2]] <= mem_wd;
  end
  assign mem_rd = mem[mem_addr[6:2]];

  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_load = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && (load_valid || access_err)) begin
      check_eq("sb_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("pulse_kind", {30'b0, access_err, load_valid}, e.is_err ? 32'd2 : 32'd1);
        check_eq("load_data", load_data, e.data);
      end
    end
  end

  function automatic logic is_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (a >= 32'(MemWords * 4)) return 1'b1;
    case (f3)
      3'd0:    return 1'b0;
      3'd1:    return a[0];
      3'd2:    return a[1:0] != 2'b00;
      3'd4:    return st;
      3'd5:    return st | a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w, b, h;
    w = ref_mem[a[6:2]];
    b = (w >> {a[1:0], 3'b000}) & 32'h0000_00ff;
    h = (w >> {a[1], 4'b0000}) & 32'h0000_ffff;
    case (f3)
      3'd0:    return b[7] ? (b | 32'hffff_ff00) : b;
      3'd1:    return h[15] ? (h | 32'hffff_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge_ref(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] wd);
    logic [31:0] w, m, d;
    w = ref_mem[a[6:2]];
    if (f3 == 3'd1) begin
      m = 32'h0000_ffff << {a[1], 4'b0000};
      d = (wd & 32'h0000_ffff) << {a[1], 4'b0000};
    end else begin
      m = 32'h0000_00ff << {a[1:0], 3'b000};
      d = (wd & 32'h0000_00ff) << {a[1:0], 3'b000};
    end
    return (w & ~m) | d;
  endfunction

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a);
    drive(1'b0, f3, a, 32'h0);
    #1;
    if (is_fault(1'b0, f3, a)) begin
      sb.push_back('{is_err: 1'b1, data: last_load});
    end else begin
      last_load = load_ref(f3, a);
      sb.push_back('{is_err: 1'b0, data: last_load});
    end
    check_eq("ld_stall", 32'(stall), 32'd0);
    check_eq("ld_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mrg;
    drive(1'b1, f3, a, wd);
    #1;
    if (is_fault(1'b1, f3, a)) begin
      sb.push_back('{is_err: 1'b1, data: last_load});
      check_eq("err_we", 32'(mem_we), 32'd0);
      check_eq("err_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
    end else if (f3 == 3'd2) begin
      check_eq("sw_we", 32'(mem_we), 32'd1);
      check_eq("sw_wd", mem_wd, wd);
      check_eq("sw_addr", mem_addr, {a[31:2], 2'b00});
      check_eq("sw_stall", 32'(stall), 32'd0);
      ref_mem[a[6:2]] = wd;
      @(posedge clk);
      #1;
    end else begin
      check_eq("rmw_c1_stall", 32'(stall), 32'd1);
      check_eq("rmw_c1_we", 32'(mem_we), 32'd0);
      mrg = merge_ref(f3, a, wd);
      @(posedge clk);
      #1;
      check_eq("rmw_c2_we", 32'(mem_we), 32'd1);
      check_eq("rmw_c2_wd", mem_wd, mrg);
      check_eq("rmw_c2_addr", mem_addr, {a[31:2], 2'b00});
      check_eq("rmw_c2_stall", 32'(stall), 32'd0);
      ref_mem[a[6:2]] = mrg;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = '0;
    tb_we      = 1'b1;
    for (int i = 0; i < int'(MemWords); i++) begin
      tb_wa = 5'(i);
      tb_wd = (32'(i) * 32'h0101_0101) ^ 32'ha500_0000;
      if (i == 0) tb_wd = 32'h80ff_0000;
      if (i == 1) tb_wd = 32'h1122_3344;
      ref_mem[i] = tb_wd;
      @(posedge clk);
      #1;
    end
    tb_we = 1'b0;

    // Reset state, including mem_we held low with a valid SW presented.
    drive(1'b1, 3'd2, 32'h10, 32'hffff_ffff);
    #1;
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_load_valid", 32'(load_valid), 32'd0);
    check_eq("rst_access_err", 32'(access_err), 32'd0);
    check_eq("rst_load_data", load_data, 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Byte RMW then back-to-back read of the updated word.
    do_store(3'd0, 32'h05, 32'h0000_00ab);
    do_load(3'd2, 32'h04);
    check_eq("mem1_after_sb", mem[1], 32'h1122_ab44);

    // Lane extraction over 0x80FF0000.
    do_load(3'd0, 32'h03);
    do_load(3'd4, 32'h03);
    do_load(3'd5, 32'h02);
    do_load(3'd1, 32'h02);
    do_load(3'd0, 32'h02);
    do_load(3'd2, 32'h00);
    idle();

    // Faults: misalignment, store-only funct3 misuse, illegal funct3, range.
    do_load(3'd1, 32'h03);
    do_store(3'd2, 32'h06, 32'h1234_5678);
    do_store(3'd4, 32'h08, 32'h0);
    do_load(3'd3, 32'h08);
    do_load(3'd2, 32'h80);
    do_store(3'd2, 32'h7c, 32'hdead_beef);
    do_store(3'd2, 32'h80, 32'hcafe_f00d);
    do_load(3'd2, 32'h7c);
    idle();
    check_eq("mem31_sw", mem[31], 32'hdead_beef);

    // Halfword RMW then readback.
    do_store(3'd1, 32'h0a, 32'h0000_1234);
    do_load(3'd5, 32'h0a);
    idle();
    check_eq("mem2_hi_half", {16'h0, mem[2][31:16]}, 32'h0000_1234);

    // Mixed random traffic, including out-of-range addresses.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 159));
      if ($urandom_range(0, 1) == 1) do_store(f3, a, $urandom);
      else do_load(f3, a);
    end
    idle();

    // Reset during the write half of an RMW drops the write.
    do_load(3'd2, 32'h0c);
    drive(1'b1, 3'd0, 32'h0c, 32'h0000_005a);
    #1;
    check_eq("rstrmw_c1_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    check_eq("rstrmw_c2_we_pre", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("rstrmw_we_drop", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    check_eq("rstrmw_word_kept", mem[3], ref_mem[3]);
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    req_valid = 1'b0;
    reset     = 1'b1;
    last_load = '0;
    @(posedge clk);
    #1;
    check_eq("post_rst_stall", 32'(stall), 32'd0);
    check_eq("post_rst_we", 32'(mem_we), 32'd0);
    check_eq("post_rst_lv", 32'(load_valid), 32'd0);
    check_eq("post_rst_err", 32'(access_err), 32'd0);
    check_eq("post_rst_ld", load_data, 32'd0);
    check_eq("post_rst_addr", mem_addr, 32'd0);
    check_eq("post_rst_wd", mem_wd, 32'd0);
    do_load(3'd2, 32'h0c);
    idle();
    idle();

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    for (int i = 0; i < int'(MemWords); i++) begin
      check_eq($sformatf("mem_final_%0d", i), mem[i], ref_mem[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
